// File: rtl/uengine_result_readback.sv
// Result readback sequencer for one Monarch chip: walks the enabled engines over SPI,
// collects status and nonces, and packs them plus a summary word into the chip's result slot.
module uengine_result_readback #(
  parameter logic [7:0] STATUS_REG            = 8'hC0,
  parameter logic [7:0] NONCE_BASE_REG        = 8'hC2,
  parameter int         MAX_NONCES_PER_ENGINE = 4
) (
  input  logic        SysClock,
  input  logic        SysReset,
  input  logic        ModuleStart,
  output logic        ModuleDone,
  input  logic [15:0] EngineMap,
  input  logic [2:0]  ActualChipIndex,
  output logic [31:0] SPI_TX,
  output logic        SPI_START,
  input  logic        SPI_DONE,
  input  logic [15:0] SPI_RX,
  output logic [8:0]  Memory_Address,
  output logic [31:0] Memory_WriteData,
  output logic        Memory_WriteEnable,
  output logic [15:0] DebugExport
);

  typedef enum logic [4:0] {
    S_IDLE        = 5'd0,
    S_INIT        = 5'd1,
    S_SCAN        = 5'd2,
    S_LOAD_TX     = 5'd3,
    S_START_SPI   = 5'd4,
    S_WAIT_SPI    = 5'd5,
    S_CAPTURE     = 5'd6,
    S_WRITE_NONCE = 5'd7,
    S_NEXT_ENGINE = 5'd8,
    S_SUMMARY     = 5'd9,
    S_DONE        = 5'd10
  } state_t;

  // Which kind of register the frame in flight is reading.
  typedef enum logic [1:0] {PH_STATUS, PH_HI, PH_LO} phase_t;

  localparam logic [2:0] MaxN = 3'(MAX_NONCES_PER_ENGINE);

  state_t      state, state_nx;
  phase_t      phase;
  logic [4:0]  engine;
  logic [2:0]  nonce, ncount;
  logic [5:0]  result_count;
  logic        overflow;
  logic [15:0] done_mask, hi_half, rx_latched;
  logic [7:0]  reg_addr;

  logic [2:0]  ncount_val, nonce_nx;
  logic        slot_free, write_nonce_en;

  assign ncount_val     = (rx_latched[2:0] > MaxN) ? MaxN : rx_latched[2:0];
  assign nonce_nx       = nonce + 3'd1;
  assign slot_free      = (result_count < 6'd31);
  assign write_nonce_en = (state == S_WRITE_NONCE) && slot_free;

  always_ff @(posedge SysClock or posedge SysReset) begin
    if (SysReset) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (ModuleStart) state_nx = S_INIT;
      S_INIT:        state_nx = S_SCAN;
      S_SCAN: begin
        if (engine[4])                   state_nx = S_SUMMARY;
        else if (EngineMap[engine[3:0]]) state_nx = S_LOAD_TX;
      end
      S_LOAD_TX:     state_nx = S_START_SPI;
      S_START_SPI:   state_nx = S_WAIT_SPI;
      S_WAIT_SPI:    if (SPI_DONE) state_nx = S_CAPTURE;
      S_CAPTURE: begin
        case (phase)
          PH_STATUS: state_nx = (ncount_val == 3'd0) ? S_NEXT_ENGINE : S_LOAD_TX;
          PH_HI:     state_nx = S_LOAD_TX;
          default:   state_nx = S_WRITE_NONCE;
        endcase
      end
      S_WRITE_NONCE: state_nx = (nonce_nx == ncount) ? S_NEXT_ENGINE : S_LOAD_TX;
      S_NEXT_ENGINE: state_nx = S_SCAN;
      S_SUMMARY:     state_nx = S_DONE;
      S_DONE:        state_nx = S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClock or posedge SysReset) begin
    if (SysReset) begin
      phase        <= PH_STATUS;
      engine       <= '0;
      nonce        <= '0;
      ncount       <= '0;
      result_count <= '0;
      overflow     <= 1'b0;
      done_mask    <= '0;
      hi_half      <= '0;
      rx_latched   <= '0;
      reg_addr     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          engine       <= '0;
          nonce        <= '0;
          ncount       <= '0;
          result_count <= '0;
          overflow     <= 1'b0;
          done_mask    <= '0;
        end
        S_SCAN: begin
          if (!engine[4]) begin
            if (EngineMap[engine[3:0]]) begin
              reg_addr <= STATUS_REG;
              phase    <= PH_STATUS;
            end else begin
              engine <= engine + 5'd1;
            end
          end
        end
        S_WAIT_SPI: if (SPI_DONE) rx_latched <= SPI_RX;
        S_CAPTURE: begin
          case (phase)
            PH_STATUS: begin
              if (rx_latched[15]) done_mask[engine[3:0]] <= 1'b1;
              ncount   <= ncount_val;
              nonce    <= '0;
              reg_addr <= NONCE_BASE_REG;
              phase    <= PH_HI;
            end
            PH_HI: begin
              hi_half  <= rx_latched;
              reg_addr <= reg_addr + 8'd1;
              phase    <= PH_LO;
            end
            default: ;
          endcase
        end
        S_WRITE_NONCE: begin
          // Once the slot is full further nonces are still read but only flagged.
          if (slot_free) result_count <= result_count + 6'd1;
          else           overflow     <= 1'b1;
          nonce    <= nonce_nx;
          reg_addr <= NONCE_BASE_REG + {4'b0000, nonce_nx, 1'b0};
          phase    <= PH_HI;
        end
        S_NEXT_ENGINE: engine <= engine + 5'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    SPI_TX = '0;
    if (state == S_LOAD_TX || state == S_START_SPI || state == S_WAIT_SPI)
      SPI_TX = {1'b1, ActualChipIndex, engine[3:0], reg_addr, 16'h0000};
  end

  always_comb begin
    Memory_Address   = '0;
    Memory_WriteData = '0;
    if (write_nonce_en) begin
      Memory_Address   = {ActualChipIndex, 6'd33 + result_count};
      Memory_WriteData = {hi_half, rx_latched};
    end else if (state == S_SUMMARY) begin
      Memory_Address   = {ActualChipIndex, 6'd32};
      Memory_WriteData = {done_mask, 7'b0, overflow, 2'b00, result_count};
    end
  end

  assign Memory_WriteEnable = write_nonce_en || (state == S_SUMMARY);
  assign SPI_START          = (state == S_START_SPI);
  assign ModuleDone         = (state == S_DONE);
  assign DebugExport        = {4'b0000, result_count, state, SPI_DONE};

endmodule

// File: tb/tb_uengine_result_readback.sv
// Directed bench for uengine_result_readback: an SPI responder model with fixed latency
// plus write/done monitors; expectations are hand-computed constants.
module tb_uengine_result_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic        ModuleStart;
  logic        ModuleDone;
  logic [15:0] EngineMap;
  logic [2:0]  ActualChipIndex;
  logic [31:0] SPI_TX;
  logic        SPI_START;
  logic        SPI_DONE;
  logic [15:0] SPI_RX;
  logic [8:0]  Memory_Address;
  logic [31:0] Memory_WriteData;
  logic        Memory_WriteEnable;
  logic [15:0] DebugExport;

  uengine_result_readback dut (
    .SysClock(clk), .SysReset(rst), .ModuleStart(ModuleStart), .ModuleDone(ModuleDone),
    .EngineMap(EngineMap), .ActualChipIndex(ActualChipIndex), .SPI_TX(SPI_TX),
    .SPI_START(SPI_START), .SPI_DONE(SPI_DONE), .SPI_RX(SPI_RX),
    .Memory_Address(Memory_Address), .Memory_WriteData(Memory_WriteData),
    .Memory_WriteEnable(Memory_WriteEnable), .DebugExport(DebugExport)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passes = 0;
  int fails = 0;

  logic [15:0] status_tab [16];
  logic [31:0] frames [$];
  logic [8:0]  waddr [$];
  logic [31:0] wdata [$];
  int          done_cnt = 0;
  int          cyc_g = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Engine 2 returns the fixed nonce words from the reference example; others encode engine/reg.
  function automatic logic [15:0] rx_for(input logic [31:0] f);
    logic [3:0] e;
    logic [7:0] r;
    e = f[27:24];
    r = f[23:16];
    if (r == 8'hC0) return status_tab[e];
    if (e == 4'd2) begin
      case (r)
        8'hC2: return 16'h1234;
        8'hC3: return 16'h5678;
        8'hC4: return 16'h9ABC;
        8'hC5: return 16'hDEF0;
        default: ;
      endcase
    end
    return {e, 4'h0, r};
  endfunction

  always @(posedge clk) cyc_g++;

  // SPI responder: SPI_DONE two negedges after START is seen, one cycle wide.
  initial begin
    int cnt;
    logic [31:0] fr;
    cnt = 0;
    fr = '0;
    SPI_DONE = 1'b0;
    SPI_RX = '0;
    forever begin
      @(negedge clk);
      SPI_DONE = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          SPI_DONE = 1'b1;
          SPI_RX = rx_for(fr);
        end
      end
      if (SPI_START) begin
        fr = SPI_TX;
        frames.push_back(SPI_TX);
        cnt = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (Memory_WriteEnable) begin
      waddr.push_back(Memory_Address);
      wdata.push_back(Memory_WriteData);
      last_wr_cyc = cyc_g;
    end
    if (ModuleDone) begin
      done_cnt++;
      done_cyc = cyc_g;
    end
  end

  task automatic clear_logs();
    frames.delete();
    waddr.delete();
    wdata.delete();
    done_cnt = 0;
  endtask

  task automatic run_pass(input logic [15:0] map, input logic [2:0] chip,
                          output int cyc, output logic ok);
    EngineMap = map;
    ActualChipIndex = chip;
    clear_logs();
    @(negedge clk);
    ModuleStart = 1'b1;
    @(negedge clk);
    ModuleStart = 1'b0;
    cyc = 1;
    while (cyc < 4000 && !ModuleDone) begin
      @(negedge clk);
      cyc++;
    end
    ok = ModuleDone;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int starts;
    int n;
    logic ok;

    for (int i = 0; i < 16; i++) status_tab[i] = 16'h0000;
    rst = 1'b1;
    ModuleStart = 1'b0;
    EngineMap = '0;
    ActualChipIndex = '0;
    repeat (2) @(negedge clk);
    check("rst_spi_tx", SPI_TX, 32'h0);
    check("rst_spi_start", {31'b0, SPI_START}, 32'h0);
    check("rst_we", {31'b0, Memory_WriteEnable}, 32'h0);
    check("rst_addr", {23'b0, Memory_Address}, 32'h0);
    check("rst_wdata", Memory_WriteData, 32'h0);
    check("rst_done", {31'b0, ModuleDone}, 32'h0);
    check("rst_debug", {16'b0, DebugExport}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty map
    run_pass(16'h0000, 3'd3, cyc, ok);
    check("empty_done_seen", {31'b0, ok}, 32'h1);
    check("empty_cycles", cyc, 20);
    check("empty_frames", frames.size(), 0);
    check("empty_nwrites", waddr.size(), 1);
    check("empty_addr", {23'b0, waddr[0]}, 32'h0E0);
    check("empty_data", wdata[0], 32'h0);
    check("empty_done_width", done_cnt, 1);
    check("empty_done_after_wr", done_cyc - last_wr_cyc, 1);

    // Single engine, two nonces
    status_tab[2] = 16'h8002;
    run_pass(16'h0004, 3'd5, cyc, ok);
    check("one_done_seen", {31'b0, ok}, 32'h1);
    check("one_nframes", frames.size(), 5);
    check("one_frame0", frames[0], 32'hD2C0_0000);
    check("one_frame1", frames[1], 32'hD2C2_0000);
    check("one_frame2", frames[2], 32'hD2C3_0000);
    check("one_frame3", frames[3], 32'hD2C4_0000);
    check("one_frame4", frames[4], 32'hD2C5_0000);
    check("one_nwrites", waddr.size(), 3);
    check("one_addr0", {23'b0, waddr[0]}, 32'h161);
    check("one_data0", wdata[0], 32'h1234_5678);
    check("one_addr1", {23'b0, waddr[1]}, 32'h162);
    check("one_data1", wdata[1], 32'h9ABC_DEF0);
    check("one_addr2", {23'b0, waddr[2]}, 32'h160);
    check("one_data2", wdata[2], 32'h0004_0002);
    check("one_done_after_wr", done_cyc - last_wr_cyc, 1);
    check("one_done_width", {31'b0, ModuleDone}, 32'h0);

    // Clamp: count field 7, done bit clear
    status_tab[7] = 16'h0007;
    run_pass(16'h0080, 3'd1, cyc, ok);
    check("clamp_done_seen", {31'b0, ok}, 32'h1);
    check("clamp_nframes", frames.size(), 9);
    check("clamp_last_frame", frames[8], 32'h97C9_0000);
    check("clamp_nwrites", waddr.size(), 5);
    check("clamp_addr3", {23'b0, waddr[3]}, 32'h064);
    check("clamp_data3", wdata[3], 32'h70C8_70C9);
    check("clamp_sum_addr", {23'b0, waddr[4]}, 32'h060);
    check("clamp_sum_data", wdata[4], 32'h0000_0004);

    // Overflow: 16 engines x 2 nonces, 31 slots
    for (int i = 0; i < 16; i++) status_tab[i] = 16'h8002;
    run_pass(16'hFFFF, 3'd2, cyc, ok);
    check("ovf_done_seen", {31'b0, ok}, 32'h1);
    check("ovf_nframes", frames.size(), 80);
    check("ovf_nwrites", waddr.size(), 32);
    check("ovf_first_addr", {23'b0, waddr[0]}, 32'h0A1);
    check("ovf_last_addr", {23'b0, waddr[30]}, 32'h0BF);
    check("ovf_last_data", wdata[30], 32'hF0C2_F0C3);
    check("ovf_sum_addr", {23'b0, waddr[31]}, 32'h0A0);
    check("ovf_sum_data", wdata[31], 32'hFFFF_011F);

    // Reset during WAIT_SPI of the third frame
    for (int i = 0; i < 16; i++) status_tab[i] = 16'h0000;
    status_tab[2] = 16'h8002;
    EngineMap = 16'h0004;
    ActualChipIndex = 3'd5;
    clear_logs();
    @(negedge clk);
    ModuleStart = 1'b1;
    @(negedge clk);
    ModuleStart = 1'b0;
    starts = 0;
    n = 0;
    while (starts < 3 && n < 500) begin
      if (SPI_START) starts++;
      if (starts < 3) begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_third_start", starts, 3);
    @(negedge clk);
    check("mid_tx_held", SPI_TX, 32'hD2C3_0000);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", SPI_TX, 32'h0);
    check("mid_rst_start", {31'b0, SPI_START}, 32'h0);
    check("mid_rst_we", {31'b0, Memory_WriteEnable}, 32'h0);
    check("mid_rst_addr", {23'b0, Memory_Address}, 32'h0);
    check("mid_rst_done", {31'b0, ModuleDone}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_no_writes", waddr.size(), 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_no_new_frames", frames.size(), 3);

    run_pass(16'h0004, 3'd5, cyc, ok);
    check("after_done_seen", {31'b0, ok}, 32'h1);
    check("after_nframes", frames.size(), 5);
    check("after_nwrites", waddr.size(), 3);
    check("after_data0", wdata[0], 32'h1234_5678);
    check("after_sum_data", wdata[2], 32'h0004_0002);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
